// File: rtl/clk_monitor_pkg.sv
// Shared types and default constants for the PLL divided-clock frequency monitor.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  localparam int DIV_NOM_DEF = 124;
  localparam int DIV_TOL_DEF = 2;
  localparam int GOOD_N_DEF  = 4;
  localparam int TIMEOUT_DEF = 512;

  localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/clk_monitor_sync_edge.sv
// Two-flop synchroniser for the divided clock plus a history flop for rising-edge detect.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_monitor.sv
// Measures clkd period in clk cycles and declares lock after GOOD_N consecutive in-window periods.
// state     | meaning
// WAIT_EDGE | no reference edge yet; first rise starts measuring
// MEASURE   | counting consecutive good periods toward lock
// LOCKED    | frequency in window, ok asserted
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int DIV_NOM = DIV_NOM_DEF,
  parameter int DIV_TOL = DIV_TOL_DEF,
  parameter int GOOD_N  = GOOD_N_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clkd,
  output logic                             ok,
  output logic                             rst_out,
  output logic [$clog2(TIMEOUT+1)-1:0]     period,
  output logic [7:0]                       err_cnt,
  output logic                             fault
);

  localparam int PW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GOOD_N + 1);
  localparam logic [PW-1:0] LO  = PW'(DIV_NOM - DIV_TOL);
  localparam logic [PW-1:0] HI  = PW'(DIV_NOM + DIV_TOL);
  localparam logic [PW-1:0] TMO = PW'(TIMEOUT);
  localparam logic [GW-1:0] GN  = GW'(GOOD_N);

  state_t          state;
  logic            rise;
  logic [PW-1:0]   cnt;
  logic [GW-1:0]   good_cnt;
  logic [GW-1:0]   good_nxt;
  logic            good;
  logic            timeout;

  sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (clkd),
    .rise  (rise)
  );

  // A rise landing on cnt == TIMEOUT wins over the timeout and is judged as a (bad) period.
  assign good     = (cnt >= LO) && (cnt <= HI);
  assign timeout  = (cnt == TMO) && !rise;
  assign good_nxt = good_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WAIT_EDGE;
      cnt      <= '0;
      good_cnt <= '0;
      ok       <= 1'b0;
      rst_out  <= 1'b1;
      period   <= '0;
      err_cnt  <= '0;
      fault    <= 1'b0;
    end else begin
      fault   <= 1'b0;
      ok      <= (state == LOCKED);
      rst_out <= ~ok;

      // Clearing on timeout spaces repeated timeouts a full window apart.
      if (rise)
        cnt <= PW'(1);
      else if (timeout)
        cnt <= '0;
      else if (cnt != TMO)
        cnt <= cnt + 1'b1;

      case (state)
        WAIT_EDGE: begin
          if (rise) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end else if (timeout) begin
            fault <= 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            period <= cnt;
            if (good) begin
              good_cnt <= good_nxt;
              if (good_nxt == GN) state <= LOCKED;
            end else begin
              good_cnt <= '0;
              fault    <= 1'b1;
            end
          end else if (timeout) begin
            fault <= 1'b1;
            state <= WAIT_EDGE;
          end
        end
        LOCKED: begin
          if (rise) begin
            period <= cnt;
            if (!good) begin
              fault    <= 1'b1;
              good_cnt <= '0;
              state    <= MEASURE;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            end
          end else if (timeout) begin
            fault <= 1'b1;
            state <= WAIT_EDGE;
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
          end
        end
        default: begin
          state    <= WAIT_EDGE;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench: a rise-time reference model queues expected fault/ok/rst_out events.
module tb_clk_monitor;

  localparam int NOM = 124;
  localparam int TOL = 2;
  localparam int GN  = 4;
  localparam int TMO = 512;

  localparam int FLT = 0, OKUP = 1, OKDN = 2, RSTDN = 3, RSTUP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clkd = 1'b0;
  logic       ok, rst_out, fault;
  logic [9:0] period;
  logic [7:0] err_cnt;

  logic       reset_s = 1'b1;
  logic       clkd_s = 1'b0;
  logic       ok_s, rst_out_s, fault_s;
  logic [5:0] period_s;
  logic [7:0] err_cnt_s;

  always #5 clk = ~clk;

  clk_monitor dut (
    .clk     (clk),
    .reset   (reset),
    .clkd    (clkd),
    .ok      (ok),
    .rst_out (rst_out),
    .period  (period),
    .err_cnt (err_cnt),
    .fault   (fault)
  );

  // Small instance makes 300 lock losses affordable in simulation time.
  clk_monitor #(.DIV_NOM(8), .DIV_TOL(1), .GOOD_N(1), .TIMEOUT(32)) dut_s (
    .clk     (clk),
    .reset   (reset_s),
    .clkd    (clkd_s),
    .ok      (ok_s),
    .rst_out (rst_out_s),
    .period  (period_s),
    .err_cnt (err_cnt_s),
    .fault   (fault_s)
  );

  typedef struct {
    int kind;
    int at;
    int per;
    int err;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  n_fault_s = 0;
  logic p_ok = 1'b0;
  logic p_rst = 1'b1;

  bit m_armed, m_locked;
  int m_run, m_err, m_per, m_last, m_tmo;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, need %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(int kind, int at, int per, int err);
    ev_t e;
    e.kind = kind; e.at = at; e.per = per; e.err = err;
    q.push_back(e);
  endfunction

  function automatic int sat(int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  function automatic void m_reset(int r);
    m_armed = 0; m_locked = 0; m_run = 0; m_err = 0; m_per = 0; m_last = r;
    m_tmo = r - 2 + TMO;
  endfunction

  // Times are clk cycles of the bench drive of a clkd rise; effects appear 3 cycles later.
  function automatic void m_timeouts(int upto);
    while (m_tmo < upto) begin
      if (m_locked) begin
        m_err = sat(m_err);
        push(FLT, m_tmo + 3, m_per, m_err);
        push(OKDN, m_tmo + 4, 0, 0);
        push(RSTUP, m_tmo + 5, 0, 0);
      end else begin
        push(FLT, m_tmo + 3, m_per, m_err);
      end
      m_locked = 0; m_armed = 0; m_run = 0;
      m_tmo += TMO + 1;
    end
  endfunction

  function automatic void m_rise(int n);
    int g;
    bit good;
    m_timeouts(n);
    if (!m_armed) begin
      m_armed = 1;
      m_run = 0;
    end else begin
      g = n - m_last;
      m_per = g;
      good = (g >= NOM - TOL) && (g <= NOM + TOL);
      if (m_locked) begin
        if (!good) begin
          m_err = sat(m_err);
          push(FLT, n + 3, m_per, m_err);
          push(OKDN, n + 4, 0, 0);
          push(RSTUP, n + 5, 0, 0);
          m_locked = 0;
          m_run = 0;
        end
      end else if (good) begin
        m_run++;
        if (m_run == GN) begin
          m_locked = 1;
          push(OKUP, n + 4, m_per, m_err);
          push(RSTDN, n + 5, 0, 0);
        end
      end else begin
        m_run = 0;
        push(FLT, n + 3, m_per, m_err);
      end
    end
    m_last = n;
    m_tmo = n + TMO;
  endfunction

  function automatic void expect_ev(int kind);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind %0d at cycle %0d", kind, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.at != cyc ||
        ((kind == FLT || kind == OKUP) && (e.per != int'(period) || e.err != int'(err_cnt)))) begin
      errors++;
      $display("FAIL event: got kind %0d cyc %0d period %0d err %0d, need kind %0d cyc %0d period %0d err %0d",
               kind, cyc, period, err_cnt, e.kind, e.at, e.per, e.err);
    end
  endfunction

  always @(negedge clk) begin
    if (fault) expect_ev(FLT);
    if (ok !== p_ok) expect_ev(ok ? OKUP : OKDN);
    if (rst_out !== p_rst) expect_ev(rst_out ? RSTUP : RSTDN);
    p_ok  <= ok;
    p_rst <= rst_out;
    if (fault_s) n_fault_s <= n_fault_s + 1;
  end

  // Drives a clkd rise now; the next rise follows g cycles later.
  task automatic send(int g);
    int n;
    n = cyc;
    m_rise(n);
    m_timeouts(n + g);
    clkd = 1'b1;
    repeat (g / 2) @(negedge clk);
    clkd = 1'b0;
    repeat (g - g / 2) @(negedge clk);
  endtask

  task automatic send_s(int g);
    clkd_s = 1'b1;
    repeat (g / 2) @(negedge clk);
    clkd_s = 1'b0;
    repeat (g - g / 2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_ok"}, ok, 0);
    chk({tag, "_rst_out"}, rst_out, 1);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  int seq1[] = '{124, 124, 124, 124, 130, 124, 124, 124, 124, 122, 126, 121,
                 124, 124, 124, 127, 124, 124, 124, 124, 122, 126, 124};

  initial begin
    int g;
    int snap;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("por");

    // err_cnt saturation on the small instance
    @(negedge clk);
    reset_s = 1'b0;
    repeat (5) @(negedge clk);
    send_s(8);
    for (int i = 1; i <= 300; i++) begin
      send_s(4);
      send_s(8);
      chk("err_sat", err_cnt_s, (i > 255) ? 255 : i);
    end
    snap = n_fault_s;
    chk("small_faults", snap, 300);
    chk("small_ok", ok_s, 0);
    chk("small_rst_out", rst_out_s, 1);
    chk("small_period", period_s, 4);
    reset_s = 1'b1;

    // main instance: lock, loss, window edges
    @(negedge clk);
    reset = 1'b0;
    m_reset(cyc);
    repeat (10) @(negedge clk);
    foreach (seq1[i]) send(seq1[i]);

    for (int i = 0; i < 40; i++) begin
      g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 200)) : int'($urandom_range(119, 129));
      send(g);
    end

    // lock, then silence long enough for a locked timeout and a WAIT_EDGE timeout
    repeat (5) send(124);
    send(1200);
    repeat (4) send(124);
    send(512);
    send(124);
    send(124);
    send(124);
    send(50);

    // reset mid-MEASURE after three good periods
    chk("pre_reset_queue", q.size(), 0);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_reset(cyc);
    repeat (10) @(negedge clk);
    repeat (4) send(124);
    chk("no_lock_after_4", ok, 0);
    send(124);
    repeat (10) @(negedge clk);
    chk("final_ok", ok, 1);
    chk("final_rst_out", rst_out, 0);
    chk("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter DIV_NOM, default 124, meaning the nominal number of clk cycles per clkd period.
REQ-002 SHALL have parameter DIV_TOL, default 2, meaning the allowed +/- deviation in cycles.
REQ-003 SHALL have parameter GOOD_N, default 4, meaning the number of consecutive good periods needed to declare lock.
REQ-004 SHALL have parameter TIMEOUT, default 512, meaning the maximum number of clk cycles between clkd rising edges before a timeout.
REQ-005 SHALL have port clk, input, 1 bit: the single clock (fast PLL output); all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port clkd, input, 1 bit: the divided PLL clock, treated as asynchronous data.
REQ-008 SHALL have port ok, output, 1 bit: high while the measured clkd frequency is in lock.
REQ-009 SHALL have port rst_out, output, 1 bit: active-high reset for downstream SD logic; it equals the registered inverse of ok.
REQ-010 SHALL have port period, output, $clog2(TIMEOUT+1) bits: the last measured period in clk cycles.
REQ-011 SHALL have port err_cnt, output, 8 bits: a saturating count of lock losses.
REQ-012 SHALL have port fault, output, 1 bit: a one-cycle pulse on any bad period or timeout.

Function
REQ-013 SHALL synchronise clkd through two flops (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-014 SHALL keep a cycle counter cnt that resets to 1 in the cycle after a rise and otherwise increments, saturating at TIMEOUT.
REQ-015 SHALL, on each rise outside WAIT_EDGE, load period with cnt and classify the period as good iff DIV_NOM-DIV_TOL <= cnt <= DIV_NOM+DIV_TOL.
REQ-016 SHALL raise a timeout when cnt reaches TIMEOUT with no rise.
REQ-017 SHALL implement the state WAIT_EDGE (reset state):
- the first rise moves to MEASURE with good_cnt=0;
- a timeout pulses fault, clears cnt, and stays in WAIT_EDGE.
REQ-018 SHALL implement the state MEASURE:
- a good rise increments good_cnt;
- when the incremented value equals GOOD_N, go to LOCKED;
- a bad rise clears good_cnt and pulses fault;
- a timeout pulses fault and goes to WAIT_EDGE.
REQ-019 SHALL implement the state LOCKED:
- ok=1;
- a good rise stays in LOCKED;
- a bad rise pulses fault, increments err_cnt, and goes to MEASURE with good_cnt=0;
- a timeout pulses fault, increments err_cnt, and goes to WAIT_EDGE.
REQ-020 SHALL assert ok in the cycle after the registered transition into LOCKED, and rst_out one cycle after that.
REQ-021 SHALL deassert ok in the cycle after leaving LOCKED.
REQ-022 SHALL saturate err_cnt at 255.
REQ-023 SHALL give a rise priority over a timeout when both occur in the same cycle, evaluating the rise against cnt = TIMEOUT (which is a bad period).
REQ-024 SHALL restrict fault to a single-cycle pulse, with no back-to-back pulses from the same event.
REQ-025 SHALL treat a glitch shorter than one clk period on clkd as undefined, but it SHALL NOT lock up the FSM.

Reset
REQ-026 SHALL, on reset assertion, set asynchronously: state=WAIT_EDGE, s1=s2=s3=0, cnt=0, good_cnt=0, ok=0, rst_out=1, period=0, err_cnt=0, fault=0.
REQ-027 SHALL release reset synchronously to clk (deassertion sampled on a clk edge), with measurement restarting from WAIT_EDGE.
REQ-028 SHALL discard any in-progress period when reset is asserted mid-operation, and SHALL leave err_cnt at 0.

Structure
REQ-029 SHALL place the state enum (WAIT_EDGE, MEASURE, LOCKED) and the default DIV_NOM/DIV_TOL/GOOD_N/TIMEOUT constants in the shared project package.
REQ-030 SHALL implement the three-flop synchroniser/edge detector as the sub-module sync_edge (ports clk, reset, d, rise).

Verification
REQ-031 SHALL cover: clkd square wave of period 124 clk -> first rise enters MEASURE; ok=1 one cycle after the 5th detected rise; period=124; rst_out=0 one cycle later.
REQ-032 SHALL cover: once locked, a single 130-cycle period -> fault pulse; err_cnt=1; ok=0; re-lock after 4 further 124-cycle periods.
REQ-033 SHALL cover: periods of 122 and 126 accepted, periods of 121 and 127 rejected (fault, good_cnt cleared).
REQ-034 SHALL cover: once locked, clkd held low -> timeout 512 cycles after the last rise; fault; WAIT_EDGE; ok=0; rst_out=1.
REQ-035 SHALL cover: reset asserted mid-MEASURE after 3 good periods -> all outputs return to reset values at once; 5 rises needed after release.
REQ-036 SHALL cover: forcing 300 lock losses -> err_cnt stops at 255.
